// File: rtl/pit_sound_mixer_if.sv
// Signal bundle between the timer/port side and the sound mixer.
// The master drives the timer samples and controls; the slave returns audio.
interface pit_sound_mixer_if;
    logic       tce;
    logic [2:0] tin;
    logic       beeper;
    logic [2:0] tmask;
    logic [1:0] vol;
    logic [9:0] pcm;
    logic       pcm_stb;
    logic       dac_out;

    modport master (
        output tce, tin, beeper, tmask, vol,
        input  pcm, pcm_stb, dac_out
    );

    modport slave (
        input  tce, tin, beeper, tmask, vol,
        output pcm, pcm_stb, dac_out
    );
endinterface

// File: rtl/pit_sound_mixer.sv
// Box-filters timer channels and beeper over WIN ticks into a PCM sample,
// then drives a first-order sigma-delta bitstream for a one-pin DAC.
module pit_sound_mixer #(
    parameter int WIN  = 32,
    parameter int WLOG = 5
) (
    input  logic               clk,
    input  logic               reset,
    pit_sound_mixer_if.slave   bus
);
    logic [WLOG-1:0] r_wcnt;
    logic [WLOG:0]   r_c0, r_c1, r_c2, r_cb;
    logic [9:0]      r_pcm;
    logic            r_stb;
    logic [9:0]      r_sd;
    logic            r_dac;

    logic            w_close;
    logic [WLOG:0]   w_c0n, w_c1n, w_c2n, w_cbn;
    logic [WLOG+2:0] w_raw;
    logic [WLOG+5:0] w_scaled;
    logic [15:0]     w_sx;
    logic [9:0]      w_sat;
    logic [10:0]     w_sd_sum;

    assign w_close = bus.tce & (r_wcnt == WLOG'(WIN - 1));

    // Counts including this cycle's sample, so the closing tick is kept.
    assign w_c0n = r_c0 + {{WLOG{1'b0}}, bus.tce & bus.tin[0] & bus.tmask[0]};
    assign w_c1n = r_c1 + {{WLOG{1'b0}}, bus.tce & bus.tin[1] & bus.tmask[1]};
    assign w_c2n = r_c2 + {{WLOG{1'b0}}, bus.tce & bus.tin[2] & bus.tmask[2]};
    assign w_cbn = r_cb + {{WLOG{1'b0}}, bus.tce & bus.beeper};

    assign w_raw = {2'b00, w_c0n} + {2'b00, w_c1n} + {2'b00, w_c2n}
                 + {1'b0, w_cbn, 1'b0};
    assign w_scaled = {3'b000, w_raw} << bus.vol;
    assign w_sx     = 16'(w_scaled);
    assign w_sat    = (w_sx > 16'd1023) ? 10'd1023 : w_sx[9:0];

    assign w_sd_sum = {1'b0, r_sd} + {1'b0, r_pcm};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wcnt <= '0;
            r_c0   <= '0;
            r_c1   <= '0;
            r_c2   <= '0;
            r_cb   <= '0;
            r_pcm  <= '0;
            r_stb  <= 1'b0;
        end else begin
            r_stb <= w_close;
            if (bus.tce) begin
                r_wcnt <= r_wcnt + WLOG'(1);
            end
            if (w_close) begin
                r_pcm <= w_sat;
                r_c0  <= '0;
                r_c1  <= '0;
                r_c2  <= '0;
                r_cb  <= '0;
            end else begin
                r_c0 <= w_c0n;
                r_c1 <= w_c1n;
                r_c2 <= w_c2n;
                r_cb <= w_cbn;
            end
        end
    end

    // Only the low ten bits feed back; the carry leaves as the DAC bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sd  <= '0;
            r_dac <= 1'b0;
        end else begin
            r_sd  <= w_sd_sum[9:0];
            r_dac <= w_sd_sum[10];
        end
    end

    assign bus.pcm     = r_pcm;
    assign bus.pcm_stb = r_stb;
    assign bus.dac_out = r_dac;
endmodule

// File: tb/tb_pit_sound_mixer.sv
// Directed checks of window filtering, volume, reset, stall and
// sigma-delta density for pit_sound_mixer with WIN=32.
module tb_pit_sound_mixer;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_pass = 0;
    int   stbs;
    int   stb_at;
    int   ones;
    int   breaks;
    logic prev;

    pit_sound_mixer_if bus ();

    pit_sound_mixer #(.WIN(32), .WLOG(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n tce pulses, one every 2nd clk; optional toggling of tin[0].
    task automatic pulses(input int n, input bit tog);
        stbs = 0;
        stb_at = -1;
        for (int i = 0; i < n; i++) begin
            if (tog) bus.tin[0] = ~bus.tin[0];
            bus.tce = 1'b1;
            step();
            if (bus.pcm_stb) begin stbs++; stb_at = i + 1; end
            bus.tce = 1'b0;
            step();
            if (bus.pcm_stb) stbs++;
        end
    endtask

    task automatic setup(input logic [2:0] t, input logic b,
                         input logic [2:0] m, input logic [1:0] v);
        bus.tin    = t;
        bus.beeper = b;
        bus.tmask  = m;
        bus.vol    = v;
    endtask

    // Count dac ones and non-alternations over n clocks after settling.
    task automatic dac_scan(input int n);
        ones = 0;
        breaks = 0;
        step();
        step();
        prev = bus.dac_out;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.dac_out) ones++;
            if (bus.dac_out == prev) breaks++;
            prev = bus.dac_out;
        end
    endtask

    task automatic window_chk(input string tag, input int exp_pcm);
        pulses(32, 1'b0);
        chk({tag, "_stbs"}, stbs, 1);
        chk({tag, "_stb_at"}, stb_at, 32);
        chk({tag, "_pcm"}, int'(bus.pcm), exp_pcm);
    endtask

    initial begin
        reset = 1'b1;
        bus.tce = 1'b0;
        setup(3'b000, 1'b0, 3'b000, 2'd0);
        step();
        step();
        chk("rst_pcm", int'(bus.pcm), 0);
        chk("rst_stb", int'(bus.pcm_stb), 0);
        chk("rst_dac", int'(bus.dac_out), 0);
        reset = 1'b0;

        setup(3'b111, 1'b1, 3'b111, 2'd0);
        window_chk("full_v0", 160);
        bus.vol = 2'd2;
        window_chk("full_v2", 640);
        bus.vol = 2'd3;
        window_chk("full_v3", 1023);

        setup(3'b000, 1'b0, 3'b001, 2'd1);
        pulses(32, 1'b1);
        chk("half_w1_stbs", stbs, 1);
        chk("half_w1_pcm", int'(bus.pcm), 32);
        pulses(32, 1'b1);
        chk("half_w2_pcm", int'(bus.pcm), 32);

        setup(3'b111, 1'b0, 3'b111, 2'd0);
        pulses(10, 1'b0);
        chk("mask_a_stbs", stbs, 0);
        bus.tmask = 3'b001;
        pulses(22, 1'b0);
        chk("mask_stbs", stbs, 1);
        chk("mask_pcm", int'(bus.pcm), 52);

        setup(3'b111, 1'b1, 3'b111, 2'd0);
        pulses(20, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_pcm", int'(bus.pcm), 0);
        chk("mrst_stb", int'(bus.pcm_stb), 0);
        chk("mrst_dac", int'(bus.dac_out), 0);
        pulses(31, 1'b0);
        chk("mrst_no_old_stb", stbs, 0);
        pulses(1, 1'b0);
        chk("mrst_new_stb", stbs, 1);
        chk("mrst_pcm2", int'(bus.pcm), 160);

        setup(3'b111, 1'b1, 3'b000, 2'd3);
        window_chk("sd512", 512);
        dac_scan(64);
        chk("sd512_ones", ones, 32);
        chk("sd512_alt", breaks, 0);

        setup(3'b111, 1'b0, 3'b000, 2'd0);
        window_chk("sd0", 0);
        dac_scan(64);
        chk("sd0_ones", ones, 0);

        setup(3'b111, 1'b1, 3'b111, 2'd3);
        window_chk("sd1023", 1023);
        dac_scan(1024);
        chk("sd1023_ones", ones, 1023);

        setup(3'b111, 1'b1, 3'b111, 2'd0);
        pulses(10, 1'b0);
        bus.tin = 3'b000;
        bus.beeper = 1'b0;
        stbs = 0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (bus.pcm_stb) stbs++;
        end
        chk("stall_stbs", stbs, 0);
        chk("stall_pcm_hold", int'(bus.pcm), 1023);
        bus.tin = 3'b111;
        bus.beeper = 1'b1;
        pulses(22, 1'b0);
        chk("stall_done_stbs", stbs, 1);
        chk("stall_pcm", int'(bus.pcm), 160);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
